// File: rtl/countdown_timer_bcd_if.sv
// Control inputs and BCD digit outputs of countdown_timer_bcd.
// master drives presets and controls; slave is the timer itself.
interface countdown_timer_bcd_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       stop;
    logic [0:3] load_sec_ones;
    logic [0:3] load_sec_tens;
    logic [0:3] load_min;
    logic [0:3] sec_ones;
    logic [0:3] sec_tens;
    logic [0:3] min;
    logic       running;
    logic       zero;
    logic       done;

    modport master (
        output tick, load, start, stop, load_sec_ones, load_sec_tens, load_min,
        input  sec_ones, sec_tens, min, running, zero, done
    );

    modport slave (
        input  tick, load, start, stop, load_sec_ones, load_sec_tens, load_min,
        output sec_ones, sec_tens, min, running, zero, done
    );
endinterface

// File: rtl/countdown_timer_bcd.sv
// M:SS BCD countdown with load/start/pause/cancel; PRESCALER_EN derives the tick from clk.
// Latency: every effect is visible one cycle after the triggering edge.
// No backpressure: inputs are sampled every cycle, priority reset > stop > load > start > tick.
module countdown_timer_bcd #(
    parameter int MAX_MIN       = 9,
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_timer_bcd_if.slave  bus
);
    if (MAX_MIN < 0 || MAX_MIN > 9) begin : g_bad_max_min
        $error("MAX_MIN must be in 0..9");
    end
    if (TICKS_PER_SEC < 1) begin : g_bad_ticks
        $error("TICKS_PER_SEC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [0:3] MAX_MIN_D = 4'(MAX_MIN);

    state_t     state;
    logic [0:3] sec_ones;
    logic [0:3] sec_tens;
    logic [0:3] min;
    logic       running;
    logic       done;
    logic       zero;
    logic       sec_tick;
    logic       last_sec;

    assign zero     = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign last_sec = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

`ifdef PRESCALER_EN
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;

    assign sec_tick = (state == RUN) && (presc == PRESC_LAST);

    // Holding at zero outside RUN also gives the clear on entry to RUN.
    always_ff @(posedge clk) begin
        if (reset || state != RUN || bus.stop) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end
`else
    assign sec_tick = bus.tick;
`endif

    function automatic logic [0:3] sat(input logic [0:3] v, input logic [0:3] lim);
        return (v > lim) ? lim : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min      <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, PAUSE: begin
                    if (bus.stop) begin
                        state    <= IDLE;
                        sec_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        min      <= 4'd0;
                    end else if (bus.load) begin
                        sec_ones <= sat(bus.load_sec_ones, 4'd9);
                        sec_tens <= sat(bus.load_sec_tens, 4'd5);
                        min      <= sat(bus.load_min, MAX_MIN_D);
                    end else if (bus.start && !zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (sec_tick) begin
                        // Count is never 0:00 here, so the minutes borrow cannot underflow.
                        if (sec_ones != 4'd0) begin
                            sec_ones <= sec_ones - 4'd1;
                        end else begin
                            sec_ones <= 4'd9;
                            if (sec_tens != 4'd0) begin
                                sec_tens <= sec_tens - 4'd1;
                            end else begin
                                sec_tens <= 4'd5;
                                min      <= min - 4'd1;
                            end
                        end
                        if (last_sec) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.stop) begin
                        state <= IDLE;
                    end else if (bus.load) begin
                        state    <= IDLE;
                        sec_ones <= sat(bus.load_sec_ones, 4'd9);
                        sec_tens <= sat(bus.load_sec_tens, 4'd5);
                        min      <= sat(bus.load_min, MAX_MIN_D);
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sec_ones = sec_ones;
    assign bus.sec_tens = sec_tens;
    assign bus.min      = min;
    assign bus.running  = running;
    assign bus.zero     = zero;
    assign bus.done     = done;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd; define PRESCALER_EN to exercise the internal tick.
module tb_countdown_timer_bcd;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    countdown_timer_bcd_if bus();

`ifdef PRESCALER_EN
    countdown_timer_bcd #(.MAX_MIN(9), .TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`else
    countdown_timer_bcd #(.MAX_MIN(9), .TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse of the selected controls, sampled at the next edge.
    task automatic drive(input logic ld, input logic st, input logic sp, input logic tk);
        bus.load  = ld;
        bus.start = st;
        bus.stop  = sp;
        bus.tick  = tk;
        step();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tick  = 1'b0;
    endtask

    task automatic preset(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        bus.load_min      = m;
        bus.load_sec_tens = t;
        bus.load_sec_ones = o;
    endtask

    function automatic logic [31:0] digits();
        return {20'd0, bus.min, bus.sec_tens, bus.sec_ones};
    endfunction

    initial begin
        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tick  = 1'b0;
        preset(4'd0, 4'd0, 4'd0);
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_digits", digits(), 32'h000);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);

`ifdef PRESCALER_EN
        // Tick port held high throughout: it must have no effect.
        preset(4'd0, 4'd0, 4'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("ps_load", digits(), 32'h003);
        bus.tick = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ps_running", 32'(bus.running), 32'd1);
        step(); step(); step();
        check("ps_hold3", digits(), 32'h003);
        step();
        check("ps_after4", digits(), 32'h002);
        for (int i = 0; i < 7; i++) step();
        check("ps_before12", digits(), 32'h001);
        check("ps_done_pre", 32'(bus.done), 32'd0);
        step();
        check("ps_after12", digits(), 32'h000);
        check("ps_done", 32'(bus.done), 32'd1);
        check("ps_stopped", 32'(bus.running), 32'd0);
        step();
        check("ps_done_clr", 32'(bus.done), 32'd0);
        bus.tick = 1'b0;
`else
        // 2:18 counting down
        preset(4'd2, 4'd1, 4'd8);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("load_218", digits(), 32'h218);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("start_run", 32'(bus.running), 32'd1);
        check("start_nodec", digits(), 32'h218);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("tick_217", digits(), 32'h217);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("tick_216", digits(), 32'h216);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("tick_215", digits(), 32'h215);
        check("run_running", 32'(bus.running), 32'd1);
        check("run_zero", 32'(bus.zero), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("cancel_a", digits(), 32'h000);

        // Double borrow and single borrow
        preset(4'd1, 4'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("borrow_059", digits(), 32'h059);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        preset(4'd0, 4'd1, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("borrow_009", digits(), 32'h009);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Expiry
        preset(4'd0, 4'd0, 4'd2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("exp_001", digits(), 32'h001);
        check("exp_done_early", 32'(bus.done), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("exp_000", digits(), 32'h000);
        check("exp_done", 32'(bus.done), 32'd1);
        check("exp_running", 32'(bus.running), 32'd0);
        check("exp_zero", 32'(bus.zero), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("exp_done_pulse", 32'(bus.done), 32'd0);
        check("exp_nowrap", digits(), 32'h000);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("done_start_ign", 32'(bus.running), 32'd0);

        // Load from DONE, pause/resume/cancel
        preset(4'd1, 4'd5, 4'd9);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("done_load", digits(), 32'h159);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_after_done", 32'(bus.running), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("pause_158", digits(), 32'h158);
        check("pause_running", 32'(bus.running), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("pause_tick_ign", digits(), 32'h158);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("resume", 32'(bus.running), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("cancel_b", digits(), 32'h000);
        check("cancel_running", 32'(bus.running), 32'd0);

        // Saturation, stop in IDLE clears, start on zero ignored
        preset(4'd12, 4'd7, 4'd15);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("saturate", digits(), 32'h959);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_stop_clr", digits(), 32'h000);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("zero_start_ign", 32'(bus.running), 32'd0);

        // Priority corner cases
        preset(4'd0, 4'd0, 4'd5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("stop_tick_dig", digits(), 32'h005);
        check("stop_tick_run", 32'(bus.running), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("start_tick_dig", digits(), 32'h005);
        check("start_tick_run", 32'(bus.running), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("tick_004", digits(), 32'h004);
        preset(4'd9, 4'd5, 4'd9);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("run_load_ign", digits(), 32'h004);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        preset(4'd0, 4'd3, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("load_start_dig", digits(), 32'h030);
        check("load_start_run", 32'(bus.running), 32'd0);

        // Reset in RUN on the final second: no done pulse
        preset(4'd0, 4'd0, 4'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        check("mid_rst_dig", digits(), 32'h000);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_run", 32'(bus.running), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
